// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART serialiser (start, DATA_BITS LSB first, optional parity, 1-2 stop bits)
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 290,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TxD
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);
  localparam logic          STOP_MAX = 1'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_param: illegal parameter value");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 sidx, sidx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 txd_n, ready_n, busy_n, done_n;
  logic                 bit_tick, accept;
  assign bit_tick = cnt == CNT_MAX;
  assign accept   = tx_valid & tx_ready;
  always_comb begin
    state_n = state;
    cnt_n   = bit_tick ? '0 : cnt + 1'b1;
    idx_n   = idx;
    sidx_n  = sidx;
    shift_n = shift;
    par_n   = par;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          state_n = START;
          shift_n = tx_data;
          par_n   = PARITY_MODE == 1 ? ~^tx_data : ^tx_data;
        end
      end
      START: if (bit_tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (bit_tick) begin
        shift_n = shift >> 1;
        idx_n   = idx == IDX_MAX ? '0 : idx + 1'b1;
        if (idx == IDX_MAX) begin
          state_n = PARITY_MODE != 0 ? PARITY : STOP;
          sidx_n  = 1'b0;
        end
      end
      PARITY: if (bit_tick) begin
        state_n = STOP;
        sidx_n  = 1'b0;
      end
      STOP: if (bit_tick) begin
        state_n = sidx == STOP_MAX ? IDLE : STOP;
        done_n  = sidx == STOP_MAX;
        sidx_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are registered, so they are derived from the next state.
    txd_n   = state_n == START  ? 1'b0 :
              state_n == DATA   ? shift_n[0] :
              state_n == PARITY ? par_n : 1'b1;
    ready_n = state_n == IDLE;
    busy_n  = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sidx     <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      TxD      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sidx     <= sidx_n;
      shift    <= shift_n;
      par      <= par_n;
      TxD      <= txd_n;
      tx_ready <= ready_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: three configurations (8E1, 8O1, 7N2) checked against a frame-level model
module tb_uart_tx_param;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] d0 = '0, d1 = '0;
  logic [6:0] d2 = '0;
  logic [2:0] v = '0;
  logic [2:0] txd, rdy, bsy, dn;
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v[0]), .tx_ready(rdy[0]), .tx_busy(bsy[0]),
    .tx_done(dn[0]), .TxD(txd[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v[1]), .tx_ready(rdy[1]), .tx_busy(bsy[1]),
    .tx_done(dn[1]), .TxD(txd[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v[2]), .tx_ready(rdy[2]), .tx_busy(bsy[2]),
    .tx_done(dn[2]), .TxD(txd[2]));
  int nd[3] = '{8, 8, 7};
  int pm[3] = '{2, 1, 0};
  int ns[3] = '{1, 1, 2};
  logic [15:0] fr[3];
  int cyc[3], nb[3], dcnt[3], bcnt[3];
  bit act[3], mdone[3];
  bit started = 0;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Model: a frame is a list of serial bits, each held CPB cycles; idle line between frames.
  always @(posedge clk) begin
    logic [8:0] w;
    int p, ones;
    started = 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        act[i] = 0;
        mdone[i] = 0;
      end else if (act[i]) begin
        cyc[i]++;
        mdone[i] = 0;
        if (cyc[i] == nb[i] * CPB) begin
          act[i] = 0;
          mdone[i] = 1;
        end
      end else begin
        mdone[i] = 0;
        if (v[i]) begin
          w = i == 0 ? {1'b0, d0} : i == 1 ? {1'b0, d1} : {2'b0, d2};
          ones = 0;
          for (int b = 0; b < nd[i]; b++) ones += int'(w[b]);
          fr[i] = '0;
          p = 1;
          for (int b = 0; b < nd[i]; b++) begin fr[i][p] = w[b]; p++; end
          if (pm[i] != 0) begin fr[i][p] = pm[i] == 1 ? (ones % 2 == 0) : (ones % 2 == 1); p++; end
          for (int s = 0; s < ns[i]; s++) begin fr[i][p] = 1'b1; p++; end
          nb[i] = p;
          cyc[i] = 0;
          act[i] = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("txd%0d", i), txd[i], act[i] ? fr[i][cyc[i] / CPB] : 1'b1);
        chk($sformatf("busy%0d", i), bsy[i], act[i]);
        chk($sformatf("ready%0d", i), rdy[i], !act[i]);
        chk($sformatf("done%0d", i), dn[i], mdone[i]);
        dcnt[i] += int'(dn[i]);
        bcnt[i] += int'(bsy[i]);
      end
    end
  end
  task automatic send(input int i, input logic [8:0] w);
    @(posedge clk);
    #1;
    if (i == 0) d0 = w[7:0];
    else if (i == 1) d1 = w[7:0];
    else d2 = w[6:0];
    v[i] = 1'b1;
    @(posedge clk);
    #1 v[i] = 1'b0;
  endtask
  task automatic capture(input int i, input int n, output logic [15:0] bits);
    int t = 0;
    bits = '0;
    @(negedge clk);
    while (txd[i] !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    chk("start_timeout", t < 200, 1);
    bits[0] = txd[i];
    for (int b = 1; b < n; b++) begin
      repeat (CPB) @(negedge clk);
      bits[b] = txd[i];
    end
  endtask
  task automatic wait_idle(input int i);
    int t = 0;
    while (rdy[i] !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    chk("idle_timeout", t < 500, 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] bits;
    int b0, dd, k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", rdy, 3'b111);
    chk("reset_txd", txd, 3'b111);
    chk("reset_busy", bsy, 3'b000);
    chk("reset_done", dn, 3'b000);
    // T1: 8E1 A5
    b0 = bcnt[0]; dd = dcnt[0];
    send(0, 9'h0A5);
    capture(0, 11, bits);
    chk("t1_frame", bits[10:0], 11'h54A);
    wait_idle(0);
    chk("t1_busy_cycles", bcnt[0] - b0, 44);
    chk("t1_done_pulses", dcnt[0] - dd, 1);
    // T2: parity values
    send(1, 9'h000);
    capture(1, 11, bits);
    chk("t2_odd_00", bits[10:0], 11'h600);
    wait_idle(1);
    send(1, 9'h0FF);
    capture(1, 11, bits);
    chk("t2_odd_ff", bits[10:0], 11'h7FE);
    wait_idle(1);
    send(0, 9'h001);
    capture(0, 11, bits);
    chk("t2_even_01", bits[10:0], 11'h602);
    wait_idle(0);
    // T3: 7N2 7F
    b0 = bcnt[2]; dd = dcnt[2];
    send(2, 9'h07F);
    capture(2, 10, bits);
    chk("t3_frame", bits[9:0], 10'h3FE);
    wait_idle(2);
    chk("t3_busy_cycles", bcnt[2] - b0, 40);
    chk("t3_done_pulses", dcnt[2] - dd, 1);
    // T4: back-to-back 55 then C3 with tx_valid held
    b0 = bcnt[0]; dd = dcnt[0];
    @(posedge clk);
    #1 d0 = 8'h55; v[0] = 1'b1;
    @(posedge clk);
    #1 d0 = 8'hC3;
    k = 0;
    do begin @(negedge clk); k++; end while (dn[0] !== 1'b1 && k < 100);
    chk("t4_first_len", k, 45);
    @(posedge clk);
    #1 v[0] = 1'b0;
    @(negedge clk);
    chk("t4_second_start", txd[0], 0);
    capture(0, 11, bits);
    chk("t4_second_frame", bits[10:0], 11'h586);
    wait_idle(0);
    chk("t4_busy_cycles", bcnt[0] - b0, 88);
    chk("t4_done_pulses", dcnt[0] - dd, 2);
    // T5: reset during data bit 3
    dd = dcnt[0];
    send(0, 9'h0F0);
    repeat (17) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_txd", txd[0], 1);
    chk("t5_ready", rdy[0], 1);
    chk("t5_done", dn[0], 0);
    send(0, 9'h03C);
    capture(0, 11, bits);
    chk("t5_frame", bits[10:0], 11'h478);
    wait_idle(0);
    chk("t5_done_pulses", dcnt[0] - dd, 1);
    // T6: input activity while busy
    dd = dcnt[1];
    send(1, 9'h096);
    fork
      capture(1, 11, bits);
      begin
        repeat (30) begin
          @(posedge clk);
          #1 d1 = d1 ^ 8'hFF; v[1] = ~v[1];
          chk("t6_ready_low", rdy[1], 0);
        end
        v[1] = 1'b0;
      end
    join
    chk("t6_frame", bits[10:0], 11'h72C);
    wait_idle(1);
    repeat (8) @(negedge clk);
    chk("t6_done_pulses", dcnt[1] - dd, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
